// File: rtl/matrix_scanner_if.sv
// Bus bundle for the LED matrix scanner: back-buffer write port, swap handshake,
// brightness control and the row/column drive outputs.
interface matrix_scanner_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int BW   = 8
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic            wr_en;
  logic [CW-1:0]   wr_col;
  logic [ROWS-1:0] wr_data;
  logic            wr_ready;
  logic            swap_req;
  logic [BW-1:0]   brightness;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            frame_start;
  logic            swap_done;

  modport master (
    output wr_en, wr_col, wr_data, swap_req, brightness,
    input  wr_ready, row, col, frame_start, swap_done
  );

  modport slave (
    input  wr_en, wr_col, wr_data, swap_req, brightness,
    output wr_ready, row, col, frame_start, swap_done
  );
endinterface

// File: rtl/matrix_scanner.sv
// Double-buffered column-multiplexed LED matrix scanner with per-slot blanking
// and brightness (PWM-by-dwell) control; buffers swap only at frame end.
module matrix_scanner #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DWELL = 64,
  parameter int BLANK = 2,
  parameter int BW    = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  matrix_scanner_if.slave   bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [31:0] BLANK_U = 32'(BLANK);

  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            ptr_q;
  logic            pending_q;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            frame_start_q;
  logic            swap_done_q;
  logic [ROWS-1:0] buf_q [2][COLS];

  logic [BW-1:0]   bright_w;
  logic            frame_end;
  logic            lit;
  logic            swap_now;
  logic            wr_ok;

  assign bright_w = bus.brightness;

  always_comb begin
    frame_end = (col_idx_q == CW'(COLS - 1)) && (dwell_q == DW'(DWELL - 1));
    dwell_d   = dwell_q + 1'b1;
    col_idx_d = col_idx_q;
    if (dwell_q == DW'(DWELL - 1)) begin
      dwell_d   = '0;
      col_idx_d = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
    end

    // Dark for the first BLANK cycles of a slot, then lit for `brightness` cycles.
    lit = (32'(dwell_q) >= BLANK_U) && ((32'(dwell_q) - BLANK_U) < 32'(bright_w));

    row_d = '0;
    col_d = '1;
    if (lit) begin
      row_d = buf_q[ptr_q][col_idx_q];
      col_d[col_idx_q] = 1'b0;
    end

    // A request landing on the frame-end cycle itself is honoured immediately.
    swap_now = frame_end && (pending_q || bus.swap_req);
    wr_ok    = bus.wr_en && !pending_q && (32'(bus.wr_col) < 32'(COLS));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_idx_q     <= '0;
      dwell_q       <= '0;
      ptr_q         <= 1'b0;
      pending_q     <= 1'b0;
      row_q         <= '0;
      col_q         <= '1;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        buf_q[0][i] <= '0;
        buf_q[1][i] <= '0;
      end
    end else begin
      col_idx_q     <= col_idx_d;
      dwell_q       <= dwell_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= (col_idx_q == '0) && (dwell_q == '0);
      swap_done_q   <= swap_now;
      if (swap_now) begin
        ptr_q     <= ~ptr_q;
        pending_q <= 1'b0;
      end else if (bus.swap_req) begin
        pending_q <= 1'b1;
      end
      // Writes target the back buffer as seen before any swap at this edge.
      if (wr_ok) begin
        buf_q[~ptr_q][bus.wr_col] <= bus.wr_data;
      end
    end
  end

  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.frame_start = frame_start_q;
  assign bus.swap_done   = swap_done_q;
  assign bus.wr_ready    = ~pending_q;
endmodule

// File: tb/tb_matrix_scanner.sv
// Randomized and directed bench for matrix_scanner against a frame-position
// reference model (ROWS=4, COLS=4, DWELL=8, BLANK=2, BW=4).
module tb_matrix_scanner;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int BL = 2;
  localparam int FR = C * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_scanner_if #(.ROWS(R), .COLS(C), .BW(4)) bus ();

  matrix_scanner #(
    .ROWS(R), .COLS(C), .DWELL(DW), .BLANK(BL), .BW(4)
  ) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: image per buffer, displayed-buffer index, pending flag,
  // and t = cycles since reset (frame position is t mod FR).
  logic [R-1:0] img [2][C];
  int           ptr;
  bit           pend;
  int           t;
  logic [R-1:0] e_row;
  logic [C-1:0] e_col;
  logic         e_fs, e_sd;

  logic       d_rst, d_we, d_swap;
  logic [1:0] d_wcol;
  logic [3:0] d_wdata, d_bright;

  int         cyc, last_fs, lit_cnt, pat_cnt, rowon_cnt, sd_cnt;
  logic [3:0] pat_row, pat_col;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic predict();
    int  pos, ci, d;
    bit  lit;
    if (!d_rst) begin
      t = 0; ptr = 0; pend = 0;
      for (int i = 0; i < C; i++) begin
        img[0][i] = '0;
        img[1][i] = '0;
      end
      e_row = '0; e_col = '1; e_fs = 1'b0; e_sd = 1'b0;
    end else begin
      pos   = t % FR;
      ci    = pos / DW;
      d     = pos % DW;
      lit   = (d >= BL) && ((d - BL) < int'(d_bright));
      e_row = lit ? img[ptr][ci] : '0;
      e_col = '1;
      if (lit) e_col[ci] = 1'b0;
      e_fs  = (pos == 0);
      e_sd  = 1'b0;
      if (d_we && !pend) img[ptr ^ 1][d_wcol] = d_wdata;
      if (pos == FR - 1 && (pend || d_swap)) begin
        ptr  = ptr ^ 1;
        pend = 0;
        e_sd = 1'b1;
      end else if (d_swap) begin
        pend = 1;
      end
      t++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst_n          = d_rst;
    bus.wr_en      = d_we;
    bus.wr_col     = d_wcol;
    bus.wr_data    = d_wdata;
    bus.swap_req   = d_swap;
    bus.brightness = d_bright;
    if (d_we || d_swap || !d_rst)
      $display("cyc %0d rst_n=%0d wr_en=%0d wr_col=%0d wr_data=%b swap_req=%0d ready=%0d bright=%0d",
               cyc, d_rst, d_we, d_wcol, d_wdata, d_swap, !pend, d_bright);
    predict();
    @(posedge clk);
    #1;
    cyc++;
    check("row", bus.row, e_row);
    check("col", bus.col, e_col);
    check("frame_start", bus.frame_start, e_fs);
    check("swap_done", bus.swap_done, e_sd);
    check("wr_ready", bus.wr_ready, !pend);
    if (bus.col !== 4'hF) lit_cnt++;
    if (bus.row !== 4'h0) rowon_cnt++;
    if (bus.row === pat_row && bus.col === pat_col) pat_cnt++;
    if (bus.swap_done === 1'b1) sd_cnt++;
    if (!d_rst) last_fs = -1;
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_gap", cyc - last_fs, FR);
      last_fs = cyc;
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wait_fs();
    bit seen = 0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      cycle();
      seen = (bus.frame_start === 1'b1);
    end
    check("frame_start_seen", seen, 1);
  endtask

  task automatic wait_sd();
    bit seen = 0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      cycle();
      seen = (bus.swap_done === 1'b1);
    end
    check("swap_done_seen", seen, 1);
  endtask

  task automatic wait_pos(int p);
    for (int i = 0; i < 2 * FR && (t % FR) != p; i++) cycle();
    check("pos_reached", t % FR, p);
  endtask

  // Counts observations over exactly one frame following a frame_start.
  task automatic frame_count();
    wait_fs();
    lit_cnt = 0; pat_cnt = 0; rowon_cnt = 0;
    run(FR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_rst = 0; d_we = 0; d_wcol = 0; d_wdata = 0; d_swap = 0; d_bright = 4'd15;
    cyc = 0; last_fs = -1; lit_cnt = 0; pat_cnt = 0; rowon_cnt = 0; sd_cnt = 0;
    pat_row = 4'h0; pat_col = 4'hF;
    t = 0; ptr = 0; pend = 0;
    run(3);

    // Blank display after reset: columns scan, rows stay dark.
    d_rst = 1;
    cycle();
    check("first_fs", bus.frame_start, 1);
    run(70);
    frame_count();
    check("blank_frame_lit", lit_cnt, 4 * 6);
    check("blank_frame_rows", rowon_cnt, 0);

    // Load an image and swap it in.
    d_we = 1; d_wcol = 2'd0; d_wdata = 4'b1010; cycle();
    d_wcol = 2'd2; d_wdata = 4'b0001; cycle();
    d_we = 0; d_swap = 1; cycle();
    d_swap = 0;
    wait_sd();
    pat_row = 4'b1010; pat_col = 4'b1110;
    frame_count();
    check("col0_lit_cycles", pat_cnt, 6);
    pat_row = 4'b0001; pat_col = 4'b1011;
    frame_count();
    check("col2_lit_cycles", pat_cnt, 6);

    // Brightness limits.
    d_bright = 4'd3;
    frame_count();
    check("bright3_lit", lit_cnt, 4 * 3);
    d_bright = 4'd0;
    frame_count();
    check("bright0_lit", lit_cnt, 0);
    d_bright = 4'd15;

    // Writes while a swap is pending are dropped; old front is preserved.
    wait_pos(5);
    d_swap = 1; cycle(); d_swap = 0;
    check("ready_low_pending", bus.wr_ready, 0);
    d_we = 1; d_wcol = 2'd1; d_wdata = 4'b1111; cycle(); d_we = 0;
    wait_sd();
    frame_count();
    check("dropped_write_rows", rowon_cnt, 0);
    d_swap = 1; cycle(); d_swap = 0;
    wait_sd();
    pat_row = 4'b1010; pat_col = 4'b1110;
    frame_count();
    check("old_front_kept", pat_cnt, 6);
    check("old_front_rows", rowon_cnt, 12);

    // Swap request exactly on the frame-end cycle.
    wait_pos(FR - 1);
    d_swap = 1; cycle(); d_swap = 0;
    check("frame_end_swap", bus.swap_done, 1);
    frame_count();
    check("frame_end_new_image", rowon_cnt, 0);

    // Reset mid col-2 slot with a swap pending.
    wait_pos(10);
    d_swap = 1; cycle(); d_swap = 0;
    wait_pos(2 * DW + 3);
    d_rst = 0; cycle();
    check("rst_row", bus.row, 0);
    check("rst_col", bus.col, 4'hF);
    check("rst_ready", bus.wr_ready, 1);
    d_rst = 1; cycle();
    check("restart_fs", bus.frame_start, 1);
    sd_cnt = 0;
    run(2 * FR);
    check("no_swap_after_rst", sd_cnt, 0);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      d_we    = 1'($urandom_range(0, 1));
      d_wcol  = 2'($urandom_range(0, 3));
      d_wdata = 4'($urandom_range(0, 15));
      d_swap  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 11) == 0) d_bright = 4'($urandom_range(0, 15));
      d_rst   = ($urandom_range(0, 299) != 0);
      cycle();
    end
    d_rst = 1; d_we = 0; d_swap = 0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matrix_scanner.md
MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of row lines (anode side, active-high).
REQ-002 SHALL have parameter COLS, default 16, number of column lines (cathode side, active-low).
REQ-003 SHALL have parameter DWELL, default 64, clock cycles per column slot; legal range DWELL > BLANK.
REQ-004 SHALL have parameter BLANK, default 2, dark cycles at the start of each slot (anti-ghosting).
REQ-005 SHALL have parameter BW, default 8, brightness input width.
REQ-006 clock  input  1  sole clock, all state updates on posedge.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 wr_en  input  1  write strobe for the back buffer.
REQ-009 wr_col  input  clog2(COLS)  column index of the write.
REQ-010 wr_data  input  ROWS  pixel bits of that column (bit r = row r).
REQ-011 wr_ready  output  1  high when writes are accepted.
REQ-012 swap_req  input  1  request to show the back buffer from the next frame.
REQ-013 brightness  input  BW  lit cycles per slot after blanking, sampled every cycle.
REQ-014 row  output  ROWS  row drive, active-high.
REQ-015 col  output  COLS  column select, active-low, at most one bit low.
REQ-016 frame_start  output  1  one-cycle pulse when column 0's slot begins.
REQ-017 swap_done  output  1  one-cycle pulse when the buffers have exchanged.

Function
REQ-018 SHALL hold two ROWS x COLS buffers (front, back) selected by a one-bit pointer; front is displayed, back is written.
REQ-019 SHALL keep col_idx (0..COLS-1) and dwell (0..DWELL-1); dwell increments every cycle; at DWELL-1, dwell wraps to 0 and col_idx increments, wrapping COLS-1 -> 0.
REQ-020 Slot state lit = (dwell >= BLANK) AND (dwell - BLANK < brightness); brightness >= DWELL-BLANK gives full on; brightness = 0 gives dark.
REQ-021 row, col SHALL be registered: the output at cycle t+1 is a function of state at cycle t; if lit, row = front[col_idx] and col = all ones except bit col_idx = 0; else row = 0 and col = all ones.
REQ-022 frame_start SHALL be registered: high in the cycle after state (col_idx=0, dwell=0).
REQ-023 A write with wr_en=1 and wr_ready=1 SHALL store wr_data into back[wr_col] at that edge; wr_col >= COLS SHALL be ignored; writes with wr_ready=0 SHALL be dropped.
REQ-024 swap_req=1 SHALL set swap_pending; wr_ready = NOT swap_pending.
REQ-025 At the frame-end cycle (col_idx=COLS-1, dwell=DWELL-1) with swap_pending=1, the pointer SHALL toggle and swap_pending clear; swap_done pulses on the next cycle.
REQ-026 swap_req arriving in the frame-end cycle itself SHALL be swapped at that edge; swap_req while already pending SHALL have no further effect.
REQ-027 After a swap, the old front becomes back; its contents are not cleared.
REQ-028 Column n's first lit output SHALL appear BLANK+1 cycles after its slot begins (dwell=0).
REQ-029 Brightness changes mid-slot SHALL take effect on the next cycle; no glitch outside REQ-021 encoding.

Reset
REQ-030 While reset_n=0 at an edge: col_idx=0, dwell=0, pointer=0, swap_pending=0, both buffers all zero.
REQ-031 The outputs after a reset edge SHALL be: row=0, col=all ones, frame_start=0, swap_done=0, wr_ready=1.
REQ-032 Reset mid-frame or with a swap pending SHALL discard the pending swap and restart scanning at column 0; the first frame_start pulses one cycle after the first edge with reset_n=1.

Verification (ROWS=4, COLS=4, DWELL=8, BLANK=2, BW=4)
REQ-033 Reset, brightness=15, no writes -> row=0 forever, col toggles low per slot, frame_start every 32 cycles.
REQ-034 Write col0=4'b1010, col2=4'b0001; pulse swap_req -> swap_done after frame end; then in col0 slot: row=1010, col=1110 for 6 cycles; in col2 slot: row=0001, col=1011.
REQ-035 brightness=3 -> each slot lit exactly 3 cycles (dwell 2..4); brightness=0 -> no lit cycles.
REQ-036 swap_req pending, wr_en with new data -> wr_ready=0, write dropped; after swap_done, back buffer equals old front.
REQ-037 swap_req asserted exactly on the frame-end cycle -> swap_done next cycle, new image in the next col0 slot.
REQ-038 reset_n=0 for one cycle mid-slot of col 2 with a swap pending -> all outputs reset, wr_ready=1, no swap_done, scanning restarts at col 0.
